// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and line-level constants
// Used by the transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - latched payload shift register and bit counter
// o_bit is the next payload bit to put on the line; o_done marks the last one.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic                  i_first,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_bit,
  output logic                  o_done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;

  // r_cnt tracks the index of the bit currently on the line while in DATA
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_cnt   <= '0;
    end else if (i_shift) begin
      r_shift <= r_shift >> 1;
      r_cnt   <= i_first ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_bit  = r_shift[0];
  assign o_done = (r_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame transmitter: FSM, parity and registered line output
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  uart_state_e r_state;
  uart_state_e w_next_state;
  logic        r_tx;
  logic        r_busy;
  logic        w_next_tx;
  logic        w_load;
  logic        w_shift;
  logic        w_first;
  logic        w_bit;
  logic        w_done;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .i_clk   (CLK),
    .i_rst   (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_first (w_first),
    .i_data  (P_DATA),
    .o_bit   (w_bit),
    .o_done  (w_done)
  );

`ifdef UART_TX_PARITY_EN
  logic r_par_en;
  logic r_par_typ;
  logic r_par_acc;

  // Running XOR of each latched bit as it goes out, so parity never sees live P_DATA
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_par_en  <= 1'b0;
      r_par_typ <= PAR_EVEN;
      r_par_acc <= 1'b0;
    end else if (w_load) begin
      r_par_en  <= PAR_EN;
      r_par_typ <= PAR_TYP;
      r_par_acc <= 1'b0;
    end else if (w_shift) begin
      r_par_acc <= r_par_acc ^ w_bit;
    end
  end
`else
  logic w_unused_par;
  assign w_unused_par = PAR_EN ^ PAR_TYP;
`endif

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state <= IDLE;
      r_tx    <= STOP_BIT;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_tx    <= w_next_tx;
      r_busy  <= (w_next_state != IDLE);
    end
  end

  // Line level is computed for the next state so TX_OUT comes straight from a flop
  always_comb begin
    w_next_state = r_state;
    w_next_tx    = STOP_BIT;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_first      = 1'b0;
    case (r_state)
      IDLE: begin
        if (DATA_VALID) begin
          w_next_state = START;
          w_next_tx    = START_BIT;
          w_load       = 1'b1;
        end
      end
      START: begin
        w_next_state = DATA;
        w_next_tx    = w_bit;
        w_shift      = 1'b1;
        w_first      = 1'b1;
      end
      DATA: begin
        if (!w_done) begin
          w_next_tx = w_bit;
          w_shift   = 1'b1;
`ifdef UART_TX_PARITY_EN
        end else if (r_par_en) begin
          w_next_state = PARITY;
          w_next_tx    = r_par_acc ^ (r_par_typ == PAR_ODD);
`endif
        end else begin
          w_next_state = STOP;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        w_next_state = STOP;
      end
`endif
      STOP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign TX_OUT = r_tx;
  assign Busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame against a frame-list model
// Expected frames follow UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx_frame;

  logic       CLK;
  logic       rst;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  int n_vec;
  int n_err;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Whole frame as line levels: start, payload LSB first, optional parity, stop
  function automatic void frame_bits(input logic [7:0] d, input logic pe, input logic pt,
                                     output bit q[$]);
    int ones;
    q.delete();
    q.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      q.push_back(d[i]);
      ones += d[i];
    end
    if (PAR_BUILT && pe) q.push_back(((ones % 2) == 1) ^ pt);
    q.push_back(1'b1);
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      chk({tag, "_tx"}, TX_OUT, 1'b1);
      chk({tag, "_busy"}, Busy, 1'b0);
    end
  endtask

  // Called in acceptance cycle N; returns after checking the idle cycle following stop
  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                           input int glitch_at, input bit hold, input bit scramble);
    bit q[$];
    frame_bits(d, pe, pt, q);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      step();
      DATA_VALID = hold;
      if (scramble) begin
        P_DATA  = 8'($urandom);
        PAR_EN  = 1'($urandom);
        PAR_TYP = 1'($urandom);
      end
      if (i + 1 == glitch_at) begin
        DATA_VALID = 1'b1;
        P_DATA     = 8'h3C;
      end
      chk($sformatf("frame_%02h_bit%0d", d, i), TX_OUT, q[i]);
      chk($sformatf("frame_%02h_busy%0d", d, i), Busy, 1'b1);
    end
    step();
    chk($sformatf("frame_%02h_gap_tx", d), TX_OUT, 1'b1);
    chk($sformatf("frame_%02h_gap_busy", d), Busy, 1'b0);
  endtask

  initial begin
    bit q[$];
    logic [7:0] d;
    logic pe, pt;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; P_DATA = 8'h00; DATA_VALID = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    step();
    step();
    chk("reset_tx", TX_OUT, 1'b1);
    chk("reset_busy", Busy, 1'b0);
    rst = 1'b0;
    idle_cycles(5, "idle");

    run_frame(8'hA5, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    idle_cycles(2, "post_a5_even");
    run_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    idle_cycles(2, "post_a5_odd");
    run_frame(8'hA5, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    idle_cycles(2, "post_a5_nopar");

    // 0x3C pulse at N+4 must never reach the line
    run_frame(8'hFF, 1'b1, 1'b0, 4, 1'b0, 1'b0);
    idle_cycles(14, "no_3c");

    // Valid held high: 0x00 then 0xFF back to back with one idle cycle between
    run_frame(8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0);
    run_frame(8'hFF, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    idle_cycles(2, "post_hold");

    // Reset at N+5 truncates the frame
    frame_bits(8'h96, 1'b1, 1'b0, q);
    P_DATA = 8'h96; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      DATA_VALID = 1'b0;
      chk($sformatf("trunc_bit%0d", i), TX_OUT, q[i]);
      chk($sformatf("trunc_busy%0d", i), Busy, 1'b1);
    end
    rst = 1'b1;
    DATA_VALID = 1'b1;
    step();
    chk("midrst_tx", TX_OUT, 1'b1);
    chk("midrst_busy", Busy, 1'b0);
    rst = 1'b0;
    DATA_VALID = 1'b0;
    idle_cycles(2, "post_rst");
    run_frame(8'h5A, 1'b1, 1'b1, 0, 1'b0, 1'b1);

    for (int k = 0; k < 40; k++) begin
      d  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      run_frame(d, pe, pt, int'($urandom_range(0, 9)), 1'($urandom), 1'b1);
      DATA_VALID = 1'b0;
      idle_cycles(int'($urandom_range(0, 3)), "rand_gap");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
